muldiv_sequencer: RTL and testbench



---
 rtl/muldiv_sequencer.sv | 94 +++++++++
 tb/tb_muldiv_sequencer.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle signed MULT/DIV engine owning HI/LO, one bit per cycle.
// Define MULDIV_DIVZERO_EXC_EN for the divide-by-zero fast path with the div_zero flag.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);
  localparam int CW = $clog2(WIDTH);
`ifdef MULDIV_DIVZERO_EXC_EN
  localparam bit FAST_ZERO = 1'b1;
`else
  localparam bit FAST_ZERO = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  state_t state, nextState;
  logic [CW-1:0] count;
  logic isDiv, negQ, negR, bZero;
  logic [WIDTH-1:0] capA, magB, quo, rem;
  logic [2*WIDTH-1:0] acc, shifted, product;
  logic [WIDTH:0] sum, trial;

  always_ff @(posedge clock or negedge reset)
    if (!reset) state <= IDLE;
    else state <= nextState;

  always_comb begin
    busy = state != IDLE;
    nextState = state == IDLE ? (start ? ((FAST_ZERO && op && b_in == '0) ? FIX : RUN) : IDLE)
              : state == RUN  ? (count == CW'(WIDTH-1) ? FIX : RUN)
              : IDLE;
  end

  // The remainder's top bit is always clear here, so dropping it in the shift is lossless.
  always_comb begin
    sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, magB} : '0);
    shifted = {acc[2*WIDTH-2:0], 1'b0};
    trial = {1'b0, shifted[2*WIDTH-1:WIDTH]} - {1'b0, magB};
    product = negQ ? -acc : acc;
    quo = negQ ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem = negR ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      count <= '0;
      isDiv <= 1'b0;
      negQ <= 1'b0;
      negR <= 1'b0;
      bZero <= 1'b0;
      capA <= '0;
      magB <= '0;
      acc <= '0;
      done <= 1'b0;
      hi <= '0;
      lo <= '0;
      div_zero <= 1'b0;
    end else begin
      done <= state == FIX;
      if (state == IDLE && start) begin
        isDiv <= op;
        negQ <= a_in[WIDTH-1] ^ b_in[WIDTH-1];
        negR <= a_in[WIDTH-1];
        bZero <= b_in == '0;
        capA <= a_in;
        magB <= b_in[WIDTH-1] ? -b_in : b_in;
        acc <= {{WIDTH{1'b0}}, (a_in[WIDTH-1] ? -a_in : a_in)};
        count <= '0;
      end else if (state == RUN) begin
        count <= count + CW'(1);
        acc <= isDiv ? (trial[WIDTH] ? shifted : {trial[WIDTH-1:0], shifted[WIDTH-1:1], 1'b1})
                     : {sum, acc[WIDTH-1:1]};
      end else if (state == FIX) begin
        div_zero <= FAST_ZERO && isDiv && bZero;
        if (!isDiv) {hi, lo} <= product;
        else if (!bZero) begin
          hi <= rem;
          lo <= quo;
        end else if (!FAST_ZERO) begin
          hi <= capA;
          lo <= '1;
        end
      end
    end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed and randomized MULT/DIV sequences checked against an arithmetic model.
module tb_muldiv_sequencer;
  logic clock = 0, reset = 1, start = 0, op = 0;
  logic [31:0] a_in = '0, b_in = '0;
  logic busy, done, div_zero;
  logic [31:0] hi, lo;
  int nVec = 0, nBad = 0;
  logic [31:0] mHi = '0, mLo = '0;
  logic mDz = 0;
  logic [31:0] eHi, eLo;
  logic eDz;
  int eLat;
  logic [64:0] dirs [8] = '{
    {1'b0, 32'd7, 32'hFFFFFFFD},
    {1'b1, 32'hFFFFFFF9, 32'd2},
    {1'b1, 32'h80000000, 32'hFFFFFFFF},
    {1'b0, 32'h80000000, 32'h80000000},
    {1'b1, 32'd7, 32'hFFFFFFFE},
    {1'b0, 32'h12345678, 32'h9ABCDEF0},
    {1'b1, 32'd5, 32'd0},
    {1'b1, 32'hFFFFFFF6, 32'd0}
  };

  muldiv_sequencer #(.WIDTH(32)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .a_in(a_in), .b_in(b_in),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .div_zero(div_zero)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nVec++;
    assert (obs === exp) else begin
      nBad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, p;
    sa = $signed(a);
    sb = $signed(b);
    eDz = 0;
    eLat = 33;
    if (!o) begin
      p = sa * sb;
      eHi = p[63:32];
      eLo = p[31:0];
    end else if (b == 0) begin
`ifdef MULDIV_DIVZERO_EXC_EN
      eHi = mHi;
      eLo = mLo;
      eDz = 1;
      eLat = 1;
`else
      eHi = a;
      eLo = '1;
`endif
    end else begin
      p = sa / sb;
      eLo = p[31:0];
      p = sa % sb;
      eHi = p[31:0];
    end
  endtask

  task automatic issue(input logic o, input logic [31:0] a, input logic [31:0] b);
    start = 1;
    op = o;
    a_in = a;
    b_in = b;
    model(o, a, b);
    @(posedge clock);
    #1 start = 0;
  endtask

  task automatic complete(input string tag, input bit noisy);
    int lat = -1;
    for (int k = 0; k < 60 && lat < 0; k++) begin
      @(negedge clock);
      if (k == 0) chk({tag, " busy"}, 64'(busy), 64'(1));
      if (done) lat = k;
      else if (noisy) begin
        start = 1'($urandom);
        a_in = $urandom;
        b_in = $urandom;
      end
    end
    start = 0;
    chk({tag, " latency"}, 64'(lat), 64'(eLat));
    chk({tag, " hi"}, 64'(hi), 64'(eHi));
    chk({tag, " lo"}, 64'(lo), 64'(eLo));
    chk({tag, " div_zero"}, 64'(div_zero), 64'(eDz));
    chk({tag, " busy in done"}, 64'(busy), 64'(0));
    mHi = eHi;
    mLo = eLo;
    mDz = eDz;
  endtask

  task automatic idle1(input string tag);
    @(negedge clock);
    chk({tag, " done width"}, 64'(done), 64'(0));
    chk({tag, " hold"}, {hi, lo}, {mHi, mLo});
  endtask

  initial begin
    bit seen;
    #1 reset = 0;
    #2;
    chk("reset busy", 64'(busy), 64'(0));
    chk("reset done", 64'(done), 64'(0));
    chk("reset hilo", {hi, lo}, 64'(0));
    chk("reset div_zero", 64'(div_zero), 64'(0));
    @(negedge clock) reset = 1;
    foreach (dirs[i]) begin
      @(negedge clock);
      issue(dirs[i][64], dirs[i][63:32], dirs[i][31:0]);
      complete("directed", 0);
      idle1("directed");
    end
    @(negedge clock);
    issue(1, 32'hFFFFFF9C, 32'd7);
    complete("noisy div", 1);
    idle1("noisy div");
    @(negedge clock);
    issue(0, 32'hDEADBEEF, 32'h00C0FFEE);
    complete("noisy mult", 1);
    idle1("noisy mult");
    @(negedge clock);
    issue(0, 32'd1000, 32'hFFFFFC18);
    complete("b2b first", 0);
    issue(1, 32'h7FFFFFFF, 32'hFFFFFFF0);
    complete("b2b second", 0);
    idle1("b2b");
    for (int i = 0; i < 24; i++) begin
      logic o;
      logic [31:0] a, b;
      o = 1'($urandom);
      a = ($urandom_range(0, 3) == 0) ? 32'($signed($urandom_range(0, 40)) - 20) : $urandom;
      b = ($urandom_range(0, 5) == 0) ? 32'd0 : ($urandom_range(0, 2) == 0) ? 32'($signed($urandom_range(0, 16)) - 8) : $urandom;
      @(negedge clock);
      issue(o, a, b);
      complete("random", 0);
      idle1("random");
    end
    @(negedge clock);
    issue(0, $urandom, $urandom);
    repeat (10) @(negedge clock);
    #2 reset = 0;
    #1;
    chk("abort busy", 64'(busy), 64'(0));
    chk("abort done", 64'(done), 64'(0));
    chk("abort hilo", {hi, lo}, 64'(0));
    chk("abort div_zero", 64'(div_zero), 64'(0));
    mHi = '0;
    mLo = '0;
    mDz = 0;
    @(negedge clock) reset = 1;
    seen = 0;
    repeat (40) begin
      @(negedge clock);
      if (done || busy) seen = 1;
    end
    chk("abort no done", 64'(seen), 64'(0));
    chk("abort hold", {hi, lo}, {mHi, mLo});
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
    $finish;
  end
endmodule
